// File: rtl/mm_sched_ctrl.sv
// mm_sched_ctrl: round-robin two-port matching-store scheduler emitting fire/bypass/overflow tokens
//   clk, rst_n                 clock, async active-low master reset
//   in{0,1}_valid/ready        token handshake (ready combinational, only in IDLE)
//   in{0,1}_mf/key/data        match flag, match key, operand
//   flush                      clear all entries (IDLE only, beats requests)
//   out_valid/ready            output token handshake
//   out_kind/src/key           0 bypass, 1 fire, 2 overflow; arriving port and key
//   out_data_a/out_data_b      stored operand (fire, else 0) / arriving operand
//   occ, full, ovf_cnt         valid-entry count, store full, saturating overflow count
module mm_sched_ctrl #(
  parameter int ENTRIES = 20,
  parameter int KEY_W   = 8,
  parameter int DATA_W  = 16,
  localparam int IW = ENTRIES > 1 ? $clog2(ENTRIES) : 1,
  localparam int OW = $clog2(ENTRIES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in0_valid,
  output logic              in0_ready,
  input  logic              in0_mf,
  input  logic [KEY_W-1:0]  in0_key,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in1_valid,
  output logic              in1_ready,
  input  logic              in1_mf,
  input  logic [KEY_W-1:0]  in1_key,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_kind,
  output logic              out_src,
  output logic [KEY_W-1:0]  out_key,
  output logic [DATA_W-1:0] out_data_a,
  output logic [DATA_W-1:0] out_data_b,
  output logic [OW-1:0]     occ,
  output logic              full,
  output logic [7:0]        ovf_cnt
);
  typedef enum logic [1:0] {IDLE, MATCH, EMIT} state_t;
  state_t state, state_d;
  logic [ENTRIES-1:0] valid;
  logic [KEY_W-1:0] key_mem [ENTRIES];
  logic [DATA_W-1:0] data_mem [ENTRIES];
  logic rr;
  logic tok_mf, tok_src;
  logic [KEY_W-1:0] tok_key;
  logic [DATA_W-1:0] tok_data;
  logic any_hit, any_free;
  logic [IW-1:0] hit_idx, free_idx;
  logic store;
  // rr=0 gives port 0 priority when both request
  assign in0_ready = state == IDLE && !flush && in0_valid && (!in1_valid || !rr);
  assign in1_ready = state == IDLE && !flush && in1_valid && (!in0_valid || rr);
  assign full = occ == OW'(ENTRIES);
  assign store = state == MATCH && tok_mf && !any_hit && !full;
  // descending scans leave the lowest matching index
  always_comb begin
    any_hit = 1'b0;
    any_free = 1'b0;
    hit_idx = '0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid[i] && key_mem[i] == tok_key) begin
        any_hit = 1'b1;
        hit_idx = IW'(i);
      end
      if (!valid[i]) begin
        any_free = 1'b1;
        free_idx = IW'(i);
      end
    end
  end
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = in0_ready || in1_ready ? MATCH : IDLE;
      MATCH:   state_d = !tok_mf || any_hit || full ? EMIT : IDLE;
      EMIT:    state_d = out_ready ? IDLE : EMIT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      occ <= '0;
      ovf_cnt <= '0;
      rr <= 1'b0;
      tok_mf <= 1'b0;
      tok_src <= 1'b0;
      tok_key <= '0;
      tok_data <= '0;
      out_valid <= 1'b0;
      out_kind <= 2'd0;
      out_src <= 1'b0;
      out_key <= '0;
      out_data_a <= '0;
      out_data_b <= '0;
    end else begin
      if (state == IDLE && flush) begin
        valid <= '0;
        occ <= '0;
      end
      if (in0_ready || in1_ready) begin
        tok_src <= in1_ready;
        tok_mf <= in1_ready ? in1_mf : in0_mf;
        tok_key <= in1_ready ? in1_key : in0_key;
        tok_data <= in1_ready ? in1_data : in0_data;
        rr <= in0_ready;
      end
      if (state == MATCH) begin
        out_src <= tok_src;
        out_key <= tok_key;
        out_data_b <= tok_data;
        out_data_a <= '0;
        if (!tok_mf) begin
          out_kind <= 2'd0;
          out_valid <= 1'b1;
        end else if (any_hit) begin
          valid[hit_idx] <= 1'b0;
          occ <= occ - OW'(1);
          out_data_a <= data_mem[hit_idx];
          out_kind <= 2'd1;
          out_valid <= 1'b1;
        end else if (!full) begin
          valid[free_idx] <= 1'b1;
          occ <= occ + OW'(1);
        end else begin
          out_kind <= 2'd2;
          out_valid <= 1'b1;
          ovf_cnt <= &ovf_cnt ? ovf_cnt : ovf_cnt + 8'd1;
        end
      end
      if (state == EMIT && out_ready) out_valid <= 1'b0;
    end
  end
  // key/data payload needs no reset: VALID alone qualifies every entry
  always_ff @(posedge clk)
    if (store) begin
      key_mem[free_idx] <= tok_key;
      data_mem[free_idx] <= tok_data;
    end
endmodule

// File: tb/tb_mm_sched_ctrl.sv
// tb_mm_sched_ctrl: directed self-checking bench for mm_sched_ctrl
module tb_mm_sched_ctrl;
  logic clk = 0, rst_n = 0;
  logic in0_valid = 0, in0_mf = 0, in1_valid = 0, in1_mf = 0;
  logic [7:0] in0_key = 0, in1_key = 0;
  logic [15:0] in0_data = 0, in1_data = 0;
  logic flush = 0, out_ready = 1;
  logic in0_ready, in1_ready, out_valid, out_src, full;
  logic [1:0] out_kind;
  logic [7:0] out_key, ovf_cnt;
  logic [15:0] out_data_a, out_data_b;
  logic [4:0] occ;
  int n_chk = 0, n_pass = 0;
  mm_sched_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_ready(in0_ready), .in0_mf(in0_mf), .in0_key(in0_key), .in0_data(in0_data),
    .in1_valid(in1_valid), .in1_ready(in1_ready), .in1_mf(in1_mf), .in1_key(in1_key), .in1_data(in1_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind), .out_src(out_src),
    .out_key(out_key), .out_data_a(out_data_a), .out_data_b(out_data_b),
    .occ(occ), .full(full), .ovf_cnt(ovf_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 0;
    {in0_valid, in1_valid, flush} = '0;
    out_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask
  // returns 1 time unit after the accept edge (DUT then in MATCH)
  task automatic send(input bit p, input bit mf, input logic [7:0] k, input logic [15:0] d);
    bit ok = 0;
    if (p) begin in1_valid = 1; in1_mf = mf; in1_key = k; in1_data = d; end
    else begin in0_valid = 1; in0_mf = mf; in0_key = k; in0_data = d; end
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = p ? in1_ready : in0_ready;
      step();
    end
    in0_valid = 0;
    in1_valid = 0;
    check("send_accepted", 32'(ok), 1);
  endtask
  initial begin
    do_reset();
    check("rst_occ", 32'(occ), 0);
    check("rst_full", 32'(full), 0);
    check("rst_ovf", 32'(ovf_cnt), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    // 1: store then fire
    send(0, 1, 8'h05, 16'h1111);
    step();
    check("t1_occ1", 32'(occ), 1);
    check("t1_no_out", 32'(out_valid), 0);
    send(1, 1, 8'h05, 16'h2222);
    step();
    check("t1_out_valid", 32'(out_valid), 1);
    check("t1_kind", 32'(out_kind), 1);
    check("t1_src", 32'(out_src), 1);
    check("t1_key", 32'(out_key), 32'h05);
    check("t1_data_a", 32'(out_data_a), 32'h1111);
    check("t1_data_b", 32'(out_data_b), 32'h2222);
    check("t1_occ0", 32'(occ), 0);
    step();
    // 2: round-robin with both ports requesting
    do_reset();
    in0_valid = 1; in0_mf = 1; in0_key = 8'h10; in0_data = 16'h0;
    in1_valid = 1; in1_mf = 1; in1_key = 8'h20; in1_data = 16'h0;
    for (int i = 0; i < 8; i++) begin
      logic [1:0] g;
      logic [1:0] exp_g [8] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
      @(negedge clk);
      g = {in1_ready, in0_ready};
      check($sformatf("t2_grant%0d", i), 32'(g), 32'(exp_g[i]));
      step();
      if (g[0]) in0_key++;
      if (g[1]) in1_key++;
    end
    in0_valid = 0; in1_valid = 0;
    step(); step();
    check("t2_occ", 32'(occ), 4);
    // 3: bypass held by backpressure
    do_reset();
    out_ready = 0;
    send(0, 0, 8'h07, 16'hABCD);
    step();
    in0_valid = 1; in1_valid = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_out_valid", 32'(out_valid), 1);
      check("t3_kind", 32'(out_kind), 0);
      check("t3_data_a", 32'(out_data_a), 0);
      check("t3_data_b", 32'(out_data_b), 32'hABCD);
      check("t3_key", 32'(out_key), 32'h07);
      check("t3_ready", 32'({in1_ready, in0_ready}), 0);
      check("t3_occ", 32'(occ), 0);
    end
    in0_valid = 0; in1_valid = 0;
    out_ready = 1;
    step();
    check("t3_released", 32'(out_valid), 0);
    // 4: fill, overflow, saturation, lowest-hit fire
    do_reset();
    for (int i = 0; i < 20; i++) begin
      send(0, 1, 8'(8'h40 + i), 16'(i));
      step();
    end
    check("t4_occ20", 32'(occ), 20);
    check("t4_full", 32'(full), 1);
    send(1, 1, 8'h80, 16'h5555);
    step();
    check("t4_ovf_kind", 32'(out_kind), 2);
    check("t4_ovf_valid", 32'(out_valid), 1);
    check("t4_ovf_src", 32'(out_src), 1);
    check("t4_ovf_data_a", 32'(out_data_a), 0);
    check("t4_ovf1", 32'(ovf_cnt), 1);
    check("t4_occ_keep", 32'(occ), 20);
    step();
    for (int i = 0; i < 256; i++) begin
      send(0, 1, 8'h81, 16'h0);
      step(); step();
    end
    check("t4_ovf_sat", 32'(ovf_cnt), 255);
    send(1, 1, 8'h43, 16'h7777);
    step();
    check("t4_fire_kind", 32'(out_kind), 1);
    check("t4_fire_data_a", 32'(out_data_a), 3);
    check("t4_fire_occ", 32'(occ), 19);
    check("t4_not_full", 32'(full), 0);
    step();
    // 5: flush beats a request
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(1, 1, 8'(8'h60 + i), 16'h0);
      step();
    end
    check("t5_occ3", 32'(occ), 3);
    flush = 1;
    in0_valid = 1; in0_mf = 1; in0_key = 8'h99; in0_data = 16'h1;
    @(negedge clk);
    check("t5_no_grant", 32'(in0_ready), 0);
    step();
    flush = 0;
    check("t5_occ0", 32'(occ), 0);
    @(negedge clk);
    check("t5_grant", 32'(in0_ready), 1);
    step();
    in0_valid = 0;
    step();
    check("t5_stored", 32'(occ), 1);
    // 6: async reset during EMIT
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(0, 1, 8'(8'h70 + i), 16'h0);
      step();
    end
    out_ready = 0;
    send(0, 0, 8'h01, 16'h2);
    step();
    check("t6_emit", 32'(out_valid), 1);
    check("t6_occ4", 32'(occ), 4);
    #2 rst_n = 0;
    #1;
    check("t6_rst_out_valid", 32'(out_valid), 0);
    check("t6_rst_occ", 32'(occ), 0);
    out_ready = 1;
    step();
    rst_n = 1;
    in0_valid = 1; in0_mf = 0;
    in1_valid = 1; in1_mf = 0;
    @(negedge clk);
    check("t6_first_grant", 32'({in1_ready, in0_ready}), 32'b01);
    step();
    in0_valid = 0; in1_valid = 0;
    step(); step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
